// File: rtl/apu_aout_sequencer_pkg.sv
// Shared constants and state encoding for the APU audio-out FIR sequencer.
package apu_aout_sequencer_pkg;

  localparam int unsigned APU_W_SAMPLE   = 16;
  localparam int unsigned APU_OSR        = 16;
  localparam int unsigned APU_SYS_CLK_HZ = 12_288_000;
  localparam int unsigned APU_TICK_HZ    = 768_000;
  localparam int unsigned APU_CLKDIV_DEF = APU_SYS_CLK_HZ / APU_TICK_HZ - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/apu_aout_tick_divider.sv
// Reloadable down-counter: ticks when enabled at zero, then reloads; sync clear.
module apu_aout_tick_divider #(
  parameter int unsigned W_DIV = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [W_DIV-1:0] i_reload,
  output logic             o_tick_c
);

  logic [W_DIV-1:0] r_cnt;

  assign o_tick_c = i_en & (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tick_c ? i_reload : r_cnt - W_DIV'(1);
    end
  end

endmodule

// File: rtl/apu_aout_sequencer.sv
// APU audio-out FIR sequencer: tick generation, sample hold buffer, underrun, output strobe.
// Build option APU_AOUT_SEQ_HOLD_ON_UNDERRUN_EN: repeat last sample on underrun (else zero).
module apu_aout_sequencer
  import apu_aout_sequencer_pkg::*;
#(
  parameter int unsigned W_SAMPLE = APU_W_SAMPLE,
  parameter int unsigned W_DIV    = 8,
  parameter int unsigned OSR      = APU_OSR
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_en,
  input  logic [W_DIV-1:0]    cfg_clkdiv,
  input  logic                clr_underrun,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W_SAMPLE-1:0] in_data,
  output logic                flt_en,
  output logic                flt_en_shift,
  output logic [W_SAMPLE-1:0] flt_d,
  input  logic [W_SAMPLE-1:0] flt_q,
  output logic                out_valid,
  output logic [W_SAMPLE-1:0] out_data,
  output logic                underrun
);

  localparam int unsigned W_PHASE = $clog2(OSR);

  state_t              r_state, w_state_nx;
  logic [W_PHASE-1:0]  r_phase, w_phase_nx;
  logic                r_buf_full, w_buf_full_nx;
  logic [W_SAMPLE-1:0] r_buf, w_buf_nx;
  logic [W_SAMPLE-1:0] r_last, w_last_nx;
  logic [W_SAMPLE-1:0] r_flt_d, w_flt_d_nx;
  logic [W_SAMPLE-1:0] r_out_data;
  logic                r_in_ready, r_flt_en, r_flt_en_shift, r_out_valid, r_underrun;
  logic                w_underrun_set;
  logic                w_hs, w_active, w_div_en, w_tick, w_frame;

  // The PRIME accept is itself the first (frame) tick, so its sample bypasses the buffer.
  assign w_hs     = in_valid & r_in_ready;
  assign w_active = cfg_en & (r_state != ST_IDLE);
  assign w_div_en = cfg_en & ((r_state == ST_RUN) | ((r_state == ST_PRIME) & w_hs));
  assign w_frame  = w_tick & (r_phase == '0);

  apu_aout_tick_divider #(
    .W_DIV (W_DIV)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (~w_active),
    .i_en     (w_div_en),
    .i_reload (cfg_clkdiv),
    .o_tick_c (w_tick)
  );

  // Next state, hold buffer and sample selection
  always_comb begin
    w_state_nx     = r_state;
    w_phase_nx     = r_phase;
    w_buf_full_nx  = r_buf_full;
    w_buf_nx       = r_buf;
    w_last_nx      = r_last;
    w_flt_d_nx     = r_flt_d;
    w_underrun_set = 1'b0;

    case (r_state)
      ST_IDLE:  if (cfg_en) w_state_nx = ST_PRIME;
      ST_PRIME: begin
        if (!cfg_en)   w_state_nx = ST_IDLE;
        else if (w_hs) w_state_nx = ST_RUN;
      end
      ST_RUN:   if (!cfg_en) w_state_nx = ST_IDLE;
      default:  w_state_nx = ST_IDLE;
    endcase

    if (w_hs) w_last_nx = in_data;
    if (w_tick) w_phase_nx = r_phase + W_PHASE'(1);

    if (w_frame) begin
      if (r_buf_full) begin
        w_flt_d_nx    = r_buf;
        w_buf_full_nx = 1'b0;
      end else if (w_hs) begin
        w_flt_d_nx = in_data;
      end else begin
        w_underrun_set = 1'b1;
`ifdef APU_AOUT_SEQ_HOLD_ON_UNDERRUN_EN
        w_flt_d_nx = r_last;
`else
        w_flt_d_nx = '0;
`endif
      end
    end else if (w_hs) begin
      w_buf_full_nx = 1'b1;
      w_buf_nx      = in_data;
    end

    if (!w_active) begin
      w_buf_full_nx = 1'b0;
      w_phase_nx    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_phase        <= '0;
      r_buf_full     <= 1'b0;
      r_buf          <= '0;
      r_last         <= '0;
      r_flt_d        <= '0;
      r_in_ready     <= 1'b0;
      r_flt_en       <= 1'b0;
      r_flt_en_shift <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out_data     <= '0;
      r_underrun     <= 1'b0;
    end else begin
      r_state        <= w_state_nx;
      r_phase        <= w_phase_nx;
      r_buf_full     <= w_buf_full_nx;
      r_buf          <= w_buf_nx;
      r_last         <= w_last_nx;
      r_flt_d        <= w_flt_d_nx;
      r_in_ready     <= (w_state_nx != ST_IDLE) & ~w_buf_full_nx;
      r_flt_en       <= w_tick;
      r_flt_en_shift <= w_frame;
      r_out_valid    <= r_flt_en;
      if (r_flt_en) r_out_data <= flt_q;
      r_underrun     <= w_underrun_set | (r_underrun & ~clr_underrun);
    end
  end

  assign in_ready     = r_in_ready;
  assign flt_en       = r_flt_en;
  assign flt_en_shift = r_flt_en_shift;
  assign flt_d        = r_flt_d;
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign underrun     = r_underrun;

endmodule

// File: tb/tb_apu_aout_sequencer.sv
// Directed self-checking bench for apu_aout_sequencer (default OSR=16, W_DIV=8).
module tb_apu_aout_sequencer;

  logic        clk = 1'b0;
  logic        rst, cfg_en, clr_underrun, in_valid, in_ready;
  logic        flt_en, flt_en_shift, out_valid, underrun;
  logic [7:0]  cfg_clkdiv;
  logic [15:0] in_data, flt_d, flt_q, out_data;

  apu_aout_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_en       (cfg_en),
    .cfg_clkdiv   (cfg_clkdiv),
    .clr_underrun (clr_underrun),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .flt_en       (flt_en),
    .flt_en_shift (flt_en_shift),
    .flt_d        (flt_d),
    .flt_q        (flt_q),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          tick_cyc[$];
  int          shift_cyc[$];
  logic [15:0] shift_d[$];
  int          n_outv, orphan, odata_bad, n_lo, p_idx;
  logic [15:0] pend_q;
  logic [15:0] smp [6];
  logic [15:0] exp_ur;
  int          s0, t0, n6, n1234;

  // Strobe monitor; each negedge is stamped with the current cycle number.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        n_outv++;
        if (out_data !== pend_q) odata_bad++;
      end
      if (flt_en) begin
        tick_cyc.push_back(cyc);
        pend_q = flt_q;
      end
      if (flt_en_shift) begin
        if (!flt_en) orphan++;
        shift_cyc.push_back(cyc);
        shift_d.push_back(flt_d);
      end
    end
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    flt_q = 16'(cyc * 305 + 165);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) step();
  endtask

  task automatic mon_clear();
    tick_cyc.delete();
    shift_cyc.delete();
    shift_d.delete();
    n_outv    = 0;
    orphan    = 0;
    odata_bad = 0;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    cfg_en       = 1'b0;
    in_valid     = 1'b0;
    clr_underrun = 1'b0;
    in_data      = 16'h0;
    cfg_clkdiv   = 8'd3;
    repeat (3) step();
    rst = 1'b0;
  endtask

  // Stream producer: offers smp[0..n_smp-1] in order, then deasserts valid.
  task automatic run_prod(input int n_smp, input int n_cyc);
    logic hs;
    for (int i = 0; i < n_cyc; i++) begin
      hs = in_valid && in_ready;
      step();
      if (!in_ready) n_lo++;
      if (hs) begin
        p_idx++;
        if (p_idx < n_smp) in_data = smp[p_idx];
        else in_valid = 1'b0;
      end
    end
  endtask

  task automatic check_stream_end(input string tag);
    cfg_en   = 1'b0;
    in_valid = 1'b0;
    repeat (3) step();
    check({tag, "_outv_eq_ticks"}, n_outv, tick_cyc.size());
    check({tag, "_orphan_shift"}, orphan, 0);
    check({tag, "_out_data"}, odata_bad, 0);
  endtask

  initial begin
    rst = 1'b1; cfg_en = 1'b0; in_valid = 1'b0; clr_underrun = 1'b0;
    in_data = '0; cfg_clkdiv = '0; flt_q = '0; pend_q = '0;
    n_outv = 0; orphan = 0; odata_bad = 0; n_lo = 0; p_idx = 0;

    // Reset values
    do_reset();
    check("rst_in_ready", in_ready, 0);
    check("rst_flt_en", flt_en, 0);
    check("rst_flt_d", flt_d, 0);
    check("rst_underrun", underrun, 0);

    // Held-valid constant sample, div 3
    mon_clear();
    cfg_clkdiv = 8'd3; in_data = 16'h1234; in_valid = 1'b1; cfg_en = 1'b1;
    s0 = cyc;
    step();
    check("t1_prime_ready", in_ready, 1);
    repeat (139) step();
    check("t1_tick_count", tick_cyc.size(), 35);
    check("t1_first_tick", (tick_cyc.size() > 1) ? tick_cyc[0] - s0 : -1, 2);
    check("t1_tick_period", (tick_cyc.size() > 1) ? tick_cyc[1] - tick_cyc[0] : -1, 4);
    check("t1_shift_count", shift_cyc.size(), 3);
    check("t1_shift17", (shift_cyc.size() == 3 && tick_cyc.size() > 32) ? shift_cyc[1] - tick_cyc[16] : -1, 0);
    check("t1_shift33", (shift_cyc.size() == 3 && tick_cyc.size() > 32) ? shift_cyc[2] - tick_cyc[32] : -1, 0);
    n1234 = 0;
    foreach (shift_d[i]) if (shift_d[i] == 16'h1234) n1234++;
    check("t1_flt_d_1234", n1234, 3);
    check("t1_underrun", underrun, 0);
    check_stream_end("t1");

    // Steady stream: in_ready low while buffer full, samples one frame late
    do_reset();
    mon_clear();
    smp[0] = 16'h1111; smp[1] = 16'h2222; smp[2] = 16'h3333;
    smp[3] = 16'h4444; smp[4] = 16'h5555; smp[5] = 16'h6666;
    p_idx = 0; n_lo = 0; in_data = smp[0]; in_valid = 1'b1; cfg_en = 1'b1;
    s0 = cyc;
    run_prod(6, 270);
    check("t2_ready_low_cycles", n_lo, 264);
    check("t2_shift_count", shift_cyc.size(), 5);
    check("t2_frame_period", (shift_cyc.size() > 1) ? shift_cyc[1] - shift_cyc[0] : -1, 64);
    for (int i = 0; i < 5; i++)
      check($sformatf("t2_flt_d%0d", i), (shift_d.size() > i) ? 32'(shift_d[i]) : 32'hdead, 32'(smp[i]));
    check_stream_end("t2");

    // Starve after two samples; clear colliding with a new underrun
    do_reset();
    mon_clear();
    smp[0] = 16'hA001; smp[1] = 16'hA002;
    p_idx = 0; in_data = smp[0]; in_valid = 1'b1; cfg_en = 1'b1;
    s0 = cyc;
    run_prod(2, 120);
    check("t3_no_underrun_yet", underrun, 0);
    repeat (15) step();
    check("t3_underrun_set", underrun, 1);
`ifdef APU_AOUT_SEQ_HOLD_ON_UNDERRUN_EN
    exp_ur = 16'hA002;
`else
    exp_ur = 16'h0000;
`endif
    check("t3_underrun_flt_d", (shift_d.size() > 2) ? 32'(shift_d[2]) : 32'hdead, 32'(exp_ur));
    wait_cyc(s0 + 193);
    clr_underrun = 1'b1;
    step();
    clr_underrun = 1'b0;
    check("t3_set_wins_clr", underrun, 1);
    wait_cyc(s0 + 200);
    clr_underrun = 1'b1;
    step();
    clr_underrun = 1'b0;
    check("t3_clr", underrun, 0);

    // Bypass: valid rises exactly on a frame decision cycle with buffer empty
    wait_cyc(s0 + 257);
    in_valid = 1'b1; in_data = 16'h5A5A;
    step();
    in_valid = 1'b0;
    check("t4_shift", flt_en_shift, 1);
    check("t4_bypass_flt_d", flt_d, 16'h5A5A);
    check("t4_buf_empty", in_ready, 1);
    check("t4_no_underrun", underrun, 0);

    // cfg_clkdiv 3 -> 7 mid-period
    do_reset();
    mon_clear();
    cfg_clkdiv = 8'd3; in_data = 16'h1234; in_valid = 1'b1; cfg_en = 1'b1;
    s0 = cyc;
    wait_cyc(s0 + 3);
    cfg_clkdiv = 8'd7;
    wait_cyc(s0 + 30);
    check("t5_tick_count", tick_cyc.size(), 4);
    check("t5_period0", (tick_cyc.size() > 3) ? tick_cyc[1] - tick_cyc[0] : -1, 4);
    check("t5_period1", (tick_cyc.size() > 3) ? tick_cyc[2] - tick_cyc[1] : -1, 8);
    check("t5_period2", (tick_cyc.size() > 3) ? tick_cyc[3] - tick_cyc[2] : -1, 8);

    // cfg_en drop at phase 5, re-PRIME, then rst mid-RUN
    do_reset();
    mon_clear();
    cfg_clkdiv = 8'd3; in_data = 16'h1234; in_valid = 1'b1; cfg_en = 1'b1;
    s0 = cyc;
    wait_cyc(s0 + 23);
    cfg_en = 1'b0;
    n6 = tick_cyc.size();
    check("t6_ticks_before_drop", n6, 6);
    repeat (20) step();
    check("t6_no_ticks_idle", tick_cyc.size(), n6);
    check("t6_idle_ready", in_ready, 0);
    in_valid = 1'b0; cfg_en = 1'b1;
    repeat (20) step();
    check("t6_no_ticks_prime", tick_cyc.size(), n6);
    check("t6_prime_ready", in_ready, 1);
    in_valid = 1'b1; in_data = 16'hBEEF; t0 = cyc;
    step();
    in_valid = 1'b0;
    check("t6_reprime_tick", flt_en & flt_en_shift, 1);
    check("t6_reprime_flt_d", flt_d, 16'hBEEF);
    repeat (70) step();
    check("t6_underrun", underrun, 1);
    rst = 1'b1;
    step();
    check("t6_rst_in_ready", in_ready, 0);
    check("t6_rst_strobes", {flt_en, flt_en_shift, out_valid}, 0);
    check("t6_rst_flt_d", flt_d, 0);
    check("t6_rst_out_data", out_data, 0);
    check("t6_rst_underrun", underrun, 0);
    rst = 1'b0;
    step();
    check("t6_after_rst_tick", t0 > 0 ? 32'(flt_en) : 32'hdead, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
